conv2d_seq_ctrl: RTL and testbench
==================================

// Module: conv2d_seq_ctrl
// PURPOSE
//  Sequencer for a time-multiplexed conv2d datapath: one MAC, one tap per cycle, instead of a fully unrolled array.
//  Walks batch/out_ch/out_h/out_w/in_ch/k_h/k_w loops and issues input, weight, bias and output addresses.
//  Issues padding mask, accumulator clear and output-write handshake. Sits between the job launcher and the MAC plus tensor RAMs.
// PARAMETERS
//  BATCH_SIZE 1 | IN_CHANNELS 2 | OUT_CHANNELS 1 | IN_HEIGHT 4 | IN_WIDTH 4 : tensor geometry
//  KERNEL_SIZE 2 : square kernel edge | STRIDE 2 : step | PADDING 0 : zero border per side
//  MAC_LATENCY 2 : cycles from last tap issue to MAC result valid (>=1)
//  Derived: OUT_H/OUT_W = (IN+2*PADDING-KERNEL_SIZE)/STRIDE+1; TAPS = IN_CHANNELS*KERNEL_SIZE^2
// PORTS
//  clk        in  1      single clock, rising edge
//  rst        in  1      asynchronous, active-high reset
//  start      in  1      job request; sampled only in IDLE
//  busy       out 1      high from first RUN cycle through DONE
//  done       out 1      one-cycle pulse at job end
//  tap_valid  out 1      tap addresses below are valid this cycle (MAC enable)
//  acc_clr    out 1      first tap of a pixel: acc = bias[b_addr] + product
//  tap_last   out 1      last tap of a pixel
//  pad_zero   out 1      tap is in the padding border; MAC uses input = 0
//  in_addr    out IN_AW  b*IC*H*W + ic*H*W + ih*W + iw (0 when pad_zero)
//  w_addr     out W_AW   oc*IC*K*K + ic*K*K + kh*K + kw
//  b_addr     out OC_AW  oc
//  out_valid  out 1      result ready for write-back
//  out_ready  in  1      write-back accepts; handshake = out_valid & out_ready
//  out_addr   out OUT_AW b*OC*OH*OW + oc*OH*OW + oh*OW + ow
//  *_AW = max(1, $clog2(element count))
// BEHAVIOUR
//  Reset: state IDLE; all counters 0; every output 0.
//  Reset mid-job aborts immediately, with no done pulse.
//  FSM: IDLE -start-> RUN -tap_last-> DRAIN (MAC_LATENCY cycles) -> WRITE.
//  WRITE -handshake, more pixels-> RUN. WRITE -handshake, last pixel-> DONE (1 cycle) -> IDLE.
//  start outside IDLE is ignored. Back-to-back start in the DONE cycle is ignored; start in IDLE is accepted.
//  RUN: one tap per cycle with tap_valid=1. Order is ic outer, then kh, then kw inner.
//  acc_clr is high on tap 0; tap_last is high on tap TAPS-1.
//  Pixel order: b outer, oc, oh, then ow inner. Pixel counters advance only on the WRITE handshake.
//  ih = oh*STRIDE+kh-PADDING and iw likewise, computed signed.
//  pad_zero = ih<0 | ih>=IN_HEIGHT | iw<0 | iw>=IN_WIDTH.
//  WRITE: out_valid and out_addr hold stable until out_ready. Stalls are unbounded, with no tap issue during a stall.
//  Per-pixel cost with out_ready=1: TAPS + MAC_LATENCY + 1 cycles.
//  start sampled at edge N gives the first RUN cycle at N+1 and done at N+1+pixels*cost.
//  tap_valid, out_valid and done are never high simultaneously.
// CONFIGURATION
//  CONV2D_SEQ_PERF_EN defined: adds cycle_cnt out 32 and stall_cnt out 32.
//   cycle_cnt counts busy cycles. stall_cnt counts WRITE cycles with out_ready=0.
//   Both clear on an accepted start and on rst, saturate at all-ones, and hold after done.
//  Not defined: both ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  conv2d_pkg: state enum (IDLE, RUN, DRAIN, WRITE, DONE).
//   Also holds functions conv_out_dim(in,k,s,p) and addr_w(n)=max(1,$clog2(n)).
//  Sub-module conv2d_idx_counter #(MAX): wrap counter with inc, clr, value and wrap outputs.
//   Chained by carry for the kw/kh/ic (tap) and ow/oh/oc/b (pixel) loops.
// TESTING
//  1 Defaults, start at edge N, out_ready=1.
//    -> busy at N+1; writes at N+11/22/33/44 with out_addr 0,1,2,3; done at N+45 only; then IDLE.
//  2 Defaults, pixel 0 taps.
//    -> w_addr 0..7; in_addr 0,1,4,5,16,17,20,21; acc_clr on tap 0 only; tap_last on tap 7.
//  3 IN 4x4, K3, S1, P1, pixel (0,0).
//    -> taps 0,1,2,3,6 have pad_zero=1 and in_addr=0; tap 4 has in_addr 0 and tap 8 has in_addr 5, both with pad_zero=0.
//  4 Hold out_ready=0 for 5 cycles on pixel 1.
//    -> out_valid held, out_addr=1 stable, no tap_valid; done delayed by 5; stall_cnt=5 when PERF_EN is defined.
//  5 Assert rst during DRAIN of pixel 2.
//    -> all outputs 0 immediately; no done; a new start runs the full job from out_addr 0.
//  6 start pulsed while busy and in the DONE cycle.
//    -> ignored, with a single done; start at the following IDLE cycle is accepted.

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d sequencer: FSM state encoding and
// geometry/address-width helper functions.
package conv2d_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        RUN   = S_RUN,
        DRAIN = S_DRAIN,
        WRITE = S_WRITE,
        DONE  = S_DONE
    } state_e;

    function automatic int conv_out_dim(input int in_dim, input int k, input int s, input int p);
        return (in_dim + 2 * p - k) / s + 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv2d_idx_counter.sv
// Modulo-MAX loop index counter; wrap_o is the carry into the next outer loop.
module conv2d_idx_counter
    import conv2d_pkg::*;
#(
    parameter  int MAX = 2,
    localparam int W   = addr_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);

    logic [W-1:0] value_q, value_d;

    assign wrap_o  = inc_i && (value_q == W'(MAX - 1));
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = wrap_o ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/conv2d_seq_ctrl.sv
// Conv2d tap/pixel sequencer driving a single time-multiplexed MAC.
// Optional CONV2D_SEQ_PERF_EN adds busy-cycle and write-stall counters.
module conv2d_seq_ctrl
    import conv2d_pkg::*;
#(
    parameter  int BATCH_SIZE   = 1,
    parameter  int IN_CHANNELS  = 2,
    parameter  int OUT_CHANNELS = 1,
    parameter  int IN_HEIGHT    = 4,
    parameter  int IN_WIDTH     = 4,
    parameter  int KERNEL_SIZE  = 2,
    parameter  int STRIDE       = 2,
    parameter  int PADDING      = 0,
    parameter  int MAC_LATENCY  = 2,
    localparam int OUT_H  = conv_out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING),
    localparam int OUT_W  = conv_out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING),
    localparam int IN_AW  = addr_w(BATCH_SIZE * IN_CHANNELS * IN_HEIGHT * IN_WIDTH),
    localparam int W_AW   = addr_w(OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE),
    localparam int OC_AW  = addr_w(OUT_CHANNELS),
    localparam int OUT_AW = addr_w(BATCH_SIZE * OUT_CHANNELS * OUT_H * OUT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              tap_valid,
    output logic              acc_clr,
    output logic              tap_last,
    output logic              pad_zero,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [OC_AW-1:0]  b_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_AW-1:0] out_addr
`ifdef CONV2D_SEQ_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int DR_W = addr_w(MAC_LATENCY);

    state_e state_q, state_d;
    logic [DR_W-1:0] drain_q, drain_d;

    logic [addr_w(KERNEL_SIZE)-1:0]  kw_v, kh_v;
    logic [addr_w(IN_CHANNELS)-1:0]  ic_v;
    logic [addr_w(OUT_W)-1:0]        ow_v;
    logic [addr_w(OUT_H)-1:0]        oh_v;
    logic [addr_w(OUT_CHANNELS)-1:0] oc_v;
    logic [addr_w(BATCH_SIZE)-1:0]   b_v;
    logic kw_wrap, kh_wrap, ic_wrap, ow_wrap, oh_wrap, oc_wrap, b_wrap;

    logic issue, accept, handshake, pad;
    int   ih, iw, in_idx, w_idx, out_idx;

    assign issue     = (state_q == RUN);
    assign accept    = (state_q == IDLE) && start;
    assign handshake = (state_q == WRITE) && out_ready;

    // Tap loops (kw inner) step every RUN cycle; pixel loops (ow inner) step on write-back.
    conv2d_idx_counter #(.MAX(KERNEL_SIZE)) u_kw (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(issue),     .value_o(kw_v), .wrap_o(kw_wrap));
    conv2d_idx_counter #(.MAX(KERNEL_SIZE)) u_kh (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(kw_wrap),   .value_o(kh_v), .wrap_o(kh_wrap));
    conv2d_idx_counter #(.MAX(IN_CHANNELS)) u_ic (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(kh_wrap),   .value_o(ic_v), .wrap_o(ic_wrap));
    conv2d_idx_counter #(.MAX(OUT_W))        u_ow (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(handshake), .value_o(ow_v), .wrap_o(ow_wrap));
    conv2d_idx_counter #(.MAX(OUT_H))        u_oh (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(ow_wrap),   .value_o(oh_v), .wrap_o(oh_wrap));
    conv2d_idx_counter #(.MAX(OUT_CHANNELS)) u_oc (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(oh_wrap),   .value_o(oc_v), .wrap_o(oc_wrap));
    conv2d_idx_counter #(.MAX(BATCH_SIZE))   u_b  (.clk(clk), .rst(rst), .clr_i(accept), .inc_i(oc_wrap),   .value_o(b_v),  .wrap_o(b_wrap));

    always_comb begin
        state_d = state_q;
        drain_d = '0;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (ic_wrap) state_d = DRAIN;
            DRAIN: begin
                if (drain_q == DR_W'(MAC_LATENCY - 1)) begin
                    state_d = WRITE;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            WRITE:   if (out_ready) state_d = b_wrap ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Signed input coordinates so the padding border shows up as negative or overflowing indices.
    always_comb begin
        ih      = int'(oh_v) * STRIDE + int'(kh_v) - PADDING;
        iw      = int'(ow_v) * STRIDE + int'(kw_v) - PADDING;
        pad     = (ih < 0) || (ih >= IN_HEIGHT) || (iw < 0) || (iw >= IN_WIDTH);
        in_idx  = ((int'(b_v) * IN_CHANNELS + int'(ic_v)) * IN_HEIGHT + ih) * IN_WIDTH + iw;
        w_idx   = ((int'(oc_v) * IN_CHANNELS + int'(ic_v)) * KERNEL_SIZE + int'(kh_v)) * KERNEL_SIZE + int'(kw_v);
        out_idx = ((int'(b_v) * OUT_CHANNELS + int'(oc_v)) * OUT_H + int'(oh_v)) * OUT_W + int'(ow_v);
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign tap_valid = issue;
    assign tap_last  = ic_wrap;
    assign acc_clr   = issue && (kw_v == '0) && (kh_v == '0) && (ic_v == '0);
    assign pad_zero  = issue && pad;
    assign in_addr   = (issue && !pad) ? IN_AW'(in_idx) : '0;
    assign w_addr    = issue ? W_AW'(w_idx) : '0;
    assign b_addr    = issue ? oc_v : '0;
    assign out_valid = (state_q == WRITE);
    assign out_addr  = out_valid ? OUT_AW'(out_idx) : '0;

`ifdef CONV2D_SEQ_PERF_EN
    logic [31:0] cycle_q, cycle_d, stall_q, stall_d;

    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        if (accept) begin
            cycle_d = '0;
            stall_d = '0;
        end else begin
            if (busy && (cycle_q != '1)) cycle_d = cycle_q + 32'd1;
            if ((state_q == WRITE) && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_conv2d_seq_ctrl.sv
// Scoreboard bench for conv2d_seq_ctrl: stimulus pushes expected taps, writes
// and done times derived from convolution geometry; a monitor pops and compares.
module tb_conv2d_seq_ctrl;

    typedef struct {
        int in_a;
        int w_a;
        int b_a;
        bit pad;
        bit clr;
        bit last;
        int cyc;
    } tap_t;

    typedef struct {
        int b, ic, oc, h, w, k, s, p;
    } cfg_t;

    localparam int MAC_LAT = 2;
    localparam int PIX     = 4;
    localparam int COST    = 2 * 2 * 2 + MAC_LAT + 1;

    logic clk = 0, rst = 1, start = 0, out_ready = 1;
    logic busy, done, tap_valid, acc_clr, tap_last, pad_zero, out_valid;
    logic [4:0] in_addr;
    logic [2:0] w_addr;
    logic [0:0] b_addr;
    logic [1:0] out_addr;

    logic start3 = 0;
    logic busy3, done3, tap_valid3, acc_clr3, tap_last3, pad_zero3, out_valid3;
    logic [4:0] in_addr3;
    logic [4:0] w_addr3;
    logic [0:0] b_addr3;
    logic [3:0] out_addr3;

`ifdef CONV2D_SEQ_PERF_EN
    logic [31:0] cycle_cnt, stall_cnt, cycle_cnt3, stall_cnt3;
`endif

    conv2d_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .tap_valid(tap_valid), .acc_clr(acc_clr), .tap_last(tap_last), .pad_zero(pad_zero),
        .in_addr(in_addr), .w_addr(w_addr), .b_addr(b_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr)
`ifdef CONV2D_SEQ_PERF_EN
        , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
    );

    conv2d_seq_ctrl #(.KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .tap_valid(tap_valid3), .acc_clr(acc_clr3), .tap_last(tap_last3), .pad_zero(pad_zero3),
        .in_addr(in_addr3), .w_addr(w_addr3), .b_addr(b_addr3),
        .out_valid(out_valid3), .out_ready(1'b1), .out_addr(out_addr3)
`ifdef CONV2D_SEQ_PERF_EN
        , .cycle_cnt(cycle_cnt3), .stall_cnt(stall_cnt3)
`endif
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int mode = 0;
    int stall_n = 0;
    int stall_acc = 0;
    int done3_cnt = 0;
    tap_t tq[$];
    tap_t q3[$];
    int   wq[$];
    int   dq[$];
    cfg_t cfg_main, cfg3;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic int out_dim(input int in_dim, input int k, input int s, input int p);
        return (in_dim + 2 * p - k) / s + 1;
    endfunction

    // Reference: decompose linear pixel and tap indices into loop coordinates.
    function automatic tap_t model_tap(input cfg_t c, input int pix, input int t, input int cyc_e);
        tap_t r;
        int ohn, own, ow, oh, oc, b, kw, kh, ic, ih, iw;
        ohn = out_dim(c.h, c.k, c.s, c.p);
        own = out_dim(c.w, c.k, c.s, c.p);
        ow  = pix % own;
        oh  = (pix / own) % ohn;
        oc  = (pix / (own * ohn)) % c.oc;
        b   = pix / (own * ohn * c.oc);
        kw  = t % c.k;
        kh  = (t / c.k) % c.k;
        ic  = t / (c.k * c.k);
        ih  = oh * c.s + kh - c.p;
        iw  = ow * c.s + kw - c.p;
        r.pad  = (ih < 0) || (ih >= c.h) || (iw < 0) || (iw >= c.w);
        r.in_a = r.pad ? 0 : ((b * c.ic + ic) * c.h + ih) * c.w + iw;
        r.w_a  = ((oc * c.ic + ic) * c.k + kh) * c.k + kw;
        r.b_a  = oc;
        r.clr  = (t == 0);
        r.last = (t == c.ic * c.k * c.k - 1);
        r.cyc  = cyc_e;
        return r;
    endfunction

    task automatic push_job(input int n);
        for (int pix = 0; pix < PIX; pix++) begin
            for (int t = 0; t < 8; t++)
                tq.push_back(model_tap(cfg_main, pix, t, (pix == 0 && t == 0) ? n : -1));
            wq.push_back(pix);
        end
        dq.push_back(n);
    endtask

    task automatic launch(output int n);
        @(negedge clk);
        start = 1;
        n = cyc + 1;
        push_job(n);
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input bit pulse, output int d);
        d = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                d = cyc;
                break;
            end
            if (pulse) start = ($urandom_range(0, 3) == 0);
        end
        if (d < 0) fail_now("done_timeout");
    endtask

    // out_ready driver, updated just after the edge so outputs have settled.
    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            1: out_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (out_valid && out_addr == 2'd1 && stall_n < 5) begin
                    out_ready = 0;
                    stall_n++;
                end else begin
                    out_ready = 1;
                end
            end
            default: out_ready = 1;
        endcase
    end

    // Monitor for the default-geometry instance.
    initial forever begin
        tap_t e;
        @(negedge clk);
        if (!rst) begin
            if (tap_valid || out_valid || done)
                check("exclusive_valid", int'(tap_valid) + int'(out_valid) + int'(done), 1);
            if (tap_valid) begin
                if (tq.size() == 0) fail_now("unexpected_tap");
                else begin
                    e = tq.pop_front();
                    checks++;
                    if (int'(in_addr) != e.in_a || int'(w_addr) != e.w_a || int'(b_addr) != e.b_a ||
                        pad_zero != e.pad || acc_clr != e.clr || tap_last != e.last) begin
                        failures++;
                        $display("FAIL tap: got in=%0d w=%0d b=%0d pad=%0d clr=%0d last=%0d expected in=%0d w=%0d b=%0d pad=%0d clr=%0d last=%0d",
                                 in_addr, w_addr, b_addr, pad_zero, acc_clr, tap_last,
                                 e.in_a, e.w_a, e.b_a, e.pad, e.clr, e.last);
                    end
                    if (e.cyc >= 0) begin
                        check("first_tap_cycle", cyc, e.cyc);
                        check("busy_in_run", int'(busy), 1);
                    end
                end
            end
            if (out_valid) begin
                if (wq.size() == 0) fail_now("unexpected_write");
                else if (out_ready) check("out_addr", int'(out_addr), wq.pop_front());
                else begin
                    stall_acc++;
                    check("out_addr_stall", int'(out_addr), wq[0]);
                end
            end
            if (done) begin
                if (dq.size() == 0) fail_now("unexpected_done");
                else check("done_cycle", cyc, dq.pop_front() + PIX * COST + stall_acc);
                stall_acc = 0;
            end
        end
    end

    // Monitor for the padded 3x3 instance: pixel 0 taps only.
    initial forever begin
        tap_t e;
        @(negedge clk);
        if (!rst) begin
            if (done3) done3_cnt++;
            if (tap_valid3 && q3.size() > 0) begin
                e = q3.pop_front();
                checks++;
                if (int'(in_addr3) != e.in_a || int'(w_addr3) != e.w_a || pad_zero3 != e.pad ||
                    acc_clr3 != e.clr || tap_last3 != e.last) begin
                    failures++;
                    $display("FAIL tap3: got in=%0d w=%0d pad=%0d clr=%0d last=%0d expected in=%0d w=%0d pad=%0d clr=%0d last=%0d",
                             in_addr3, w_addr3, pad_zero3, acc_clr3, tap_last3, e.in_a, e.w_a, e.pad, e.clr, e.last);
                end
                if (e.cyc >= 0) check("tap3_first_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n, d, n2, lasts;
        cfg_main = '{b: 1, ic: 2, oc: 1, h: 4, w: 4, k: 2, s: 2, p: 0};
        cfg3     = '{b: 1, ic: 2, oc: 1, h: 4, w: 4, k: 3, s: 1, p: 1};

        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy, done, tap_valid, acc_clr, tap_last, pad_zero, out_valid,
                                     in_addr, w_addr, b_addr, out_addr}), 0);
        rst = 0;
        repeat (2) @(negedge clk);
        check("idle_after_reset", int'({busy, done, tap_valid, out_valid}), 0);

        // Nominal job with out_ready held high.
        mode = 0;
        launch(n);
        wait_done(0, d);
        check("job1_done_offset", d - n, PIX * COST);
        @(negedge clk);
        check("job1_idle", int'(busy), 0);
`ifdef CONV2D_SEQ_PERF_EN
        check("job1_cycle_cnt", int'(cycle_cnt), PIX * COST + 1);
        check("job1_stall_cnt", int'(stall_cnt), 0);
`endif

        // Five-cycle write-back stall on pixel 1.
        mode = 2;
        stall_n = 0;
        launch(n);
        wait_done(0, d);
        check("stall_done_offset", d - n, PIX * COST + 5);
        @(negedge clk);
`ifdef CONV2D_SEQ_PERF_EN
        check("stall_cnt_5", int'(stall_cnt), 5);
`endif
        mode = 0;

        // Random stalls, start pulses while busy, start held through DONE into IDLE.
        mode = 1;
        launch(n);
        wait_done(1, d);
        start = 1;
        n2 = d + 2;
        push_job(n2);
        @(negedge clk);
        check("done_start_ignored", int'(busy), 0);
        @(negedge clk);
        start = 0;
        wait_done(1, d);
        start = 1;
        @(negedge clk);
        start = 0;
        check("idle_after_done_pulse", int'(busy), 0);
        @(negedge clk);
        check("done_pulse_not_accepted", int'(busy), 0);
        mode = 0;

        // Abort during DRAIN of pixel 2.
        launch(n);
        lasts = 0;
        for (int i = 0; i < 200 && lasts < 3; i++) begin
            @(negedge clk);
            if (tap_valid && tap_last) lasts++;
        end
        check("reached_pixel2_last_tap", lasts, 3);
        @(posedge clk);
        #1;
        check("drain_busy_no_valid", int'({busy, tap_valid, out_valid}), 4);
        rst = 1;
        #1;
        check("abort_outputs_zero", int'({busy, done, tap_valid, acc_clr, tap_last, pad_zero, out_valid,
                                          in_addr, w_addr, b_addr, out_addr}), 0);
        tq.delete();
        wq.delete();
        dq.delete();
        stall_acc = 0;
        repeat (2) @(negedge clk);
        rst = 0;
`ifdef CONV2D_SEQ_PERF_EN
        check("abort_cycle_cnt", int'(cycle_cnt), 0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_done_after_abort", int'({busy, done}), 0);
        end
        launch(n);
        wait_done(0, d);
        check("rerun_done_offset", d - n, PIX * COST);

        // Padded 3x3 stride-1 geometry, pixel (0,0).
        @(negedge clk);
        start3 = 1;
        n = cyc + 1;
        for (int t = 0; t < 18; t++) q3.push_back(model_tap(cfg3, 0, t, (t == 0) ? n : -1));
        @(negedge clk);
        start3 = 0;
        d = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done3) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) fail_now("dut3_done_timeout");
        check("dut3_done_offset", d - n, 16 * (18 + MAC_LAT + 1));
        repeat (3) @(negedge clk);
        check("dut3_single_done", done3_cnt, 1);
        check("dut3_taps_consumed", q3.size(), 0);

        check("taps_left", tq.size(), 0);
        check("writes_left", wq.size(), 0);
        check("dones_left", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
